led_pattern_ctrl: RTL and testbench

- Parametrised successor to the fixed 8-LED blinker/delay pair.
- Generates a stepped LED pattern with four selectable modes and a programmable step period.
- The period is adjustable from one-shot key pulses (faster/slower) and from an HPS bridge register write port carrying address and data.
- Sits between the key one-shot logic and the HPS-exported write interface on the FPGA side, and drives the LED pins directly.

---
 rtl/led_pattern_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: stepped LED pattern generator with four modes and a
// programmable step period, adjustable from key pulses and an HPS write port.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   faster     one-cycle pulse, decrement delay (saturates at 0)
//   slower     one-cycle pulse, increment delay (saturates at max)
//   pause      level, freezes pattern and step timing
//   write      one-cycle register write strobe
//   address    register select: 0 delay, 1 mode, 2 pattern, 3 control
//   writedata  write data
//   led        LED drive (registered)
//   delay      current delay register; step period = (delay+1) base ticks
//   mode       current mode: 0 rotl, 1 rotr, 2 bounce, 3 binary count
//   step       one-cycle pulse coinciding with each pattern update
module led_pattern_ctrl #(
    parameter int unsigned LED_W      = 8,
    parameter int unsigned DELAY_W    = 4,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned DELAY_INIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               faster,
    input  logic               slower,
    input  logic               pause,
    input  logic               write,
    input  logic [1:0]         address,
    input  logic [7:0]         writedata,
    output logic [LED_W-1:0]   led,
    output logic [DELAY_W-1:0] delay,
    output logic [1:0]         mode,
    output logic               step
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [DELAY_W-1:0] DELAY_MAX = '1;

    // Bounce direction is the only state machine in the block.
    localparam logic [0:0] DIR_LEFT  = 1'b0;
    localparam logic [0:0] DIR_RIGHT = 1'b1;

    localparam logic [1:0] MODE_ROL    = 2'd0;
    localparam logic [1:0] MODE_ROR    = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    localparam logic [1:0] ADDR_DELAY   = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    logic [PRE_W-1:0]   pre_q,        pre_d;
    logic [DELAY_W-1:0] cnt_q,        cnt_d;
    logic [LED_W-1:0]   pattern_q,    pattern_d;
    logic               soft_pause_q, soft_pause_d;
    logic [0:0]         dir_q,        dir_d;
    logic [LED_W-1:0]   led_d;
    logic [DELAY_W-1:0] delay_d;
    logic [1:0]         mode_d;
    logic               step_d;

    logic             hold_c;
    logic             restart_c;
    logic             tick_c;
    logic             fire_c;
    logic [LED_W-1:0] rol_c;
    logic [LED_W-1:0] ror_c;

    // Strobes and pattern primitives shared by the next-state logic.
    always_comb begin
        hold_c    = pause | soft_pause_q;
        restart_c = write && (address == ADDR_CTRL) && writedata[1];
        tick_c    = !hold_c && (pre_q == PRE_LAST);
        // >= rather than == so a lowered delay fires on the very next tick.
        fire_c    = tick_c && (cnt_q >= delay);
        rol_c     = {led[LED_W-2:0], led[LED_W-1]};
        ror_c     = {led[0], led[LED_W-1:1]};
    end

    // Next-state logic for timing, pattern, bounce direction and registers.
    always_comb begin
        pre_d        = pre_q;
        cnt_d        = cnt_q;
        pattern_d    = pattern_q;
        soft_pause_d = soft_pause_q;
        dir_d        = dir_q;
        led_d        = led;
        delay_d      = delay;
        mode_d       = mode;
        step_d       = 1'b0;

        if (!hold_c) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        end
        if (tick_c) begin
            cnt_d = fire_c ? '0 : cnt_q + DELAY_W'(1);
        end

        if (fire_c) begin
            step_d = 1'b1;
            case (mode)
                MODE_ROL:    led_d = rol_c;
                MODE_ROR:    led_d = ror_c;
                MODE_BOUNCE: begin
                    if (dir_q == DIR_LEFT) begin
                        if (led[LED_W-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = ror_c;
                        end else begin
                            led_d = rol_c;
                        end
                    end else begin
                        if (led[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = rol_c;
                        end else begin
                            led_d = ror_c;
                        end
                    end
                end
                MODE_COUNT:  led_d = led + LED_W'(1);
                default:     led_d = led;
            endcase
        end

        // Register writes; a mode write cannot coincide with a bounce step
        // that moves dir because the old mode is not bounce in that case.
        if (write) begin
            case (address)
                ADDR_MODE: begin
                    mode_d = writedata[1:0];
                    if ((writedata[1:0] == MODE_BOUNCE) && (mode != MODE_BOUNCE)) begin
                        dir_d = DIR_LEFT;
                    end
                end
                ADDR_PATTERN: pattern_d    = writedata[LED_W-1:0];
                ADDR_CTRL:    soft_pause_d = writedata[0];
                default:      ;
            endcase
        end

        // Restart wins over a coincident step, even while held.
        if (restart_c) begin
            led_d  = pattern_q;
            pre_d  = '0;
            cnt_d  = '0;
            dir_d  = DIR_LEFT;
            step_d = 1'b0;
        end

        // Delay: register write beats key pulses; both keys cancel.
        if (write && (address == ADDR_DELAY)) begin
            delay_d = writedata[DELAY_W-1:0];
        end else if (faster && !slower) begin
            if (delay != '0) delay_d = delay - DELAY_W'(1);
        end else if (slower && !faster) begin
            if (delay != DELAY_MAX) delay_d = delay + DELAY_W'(1);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            pattern_q    <= LED_W'(1);
            soft_pause_q <= 1'b0;
            dir_q        <= DIR_LEFT;
            led          <= LED_W'(1);
            delay        <= DELAY_W'(DELAY_INIT);
            mode         <= MODE_ROL;
            step         <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            pattern_q    <= pattern_d;
            soft_pause_q <= soft_pause_d;
            dir_q        <= dir_d;
            led          <= led_d;
            delay        <= delay_d;
            mode         <= mode_d;
            step         <= step_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: vector table, directed sequences and randomized
// stimulus against a behavioural model of led_pattern_ctrl.
module tb_led_pattern_ctrl;

    localparam int unsigned LED_W      = 8;
    localparam int unsigned DELAY_W    = 4;
    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned DELAY_INIT = 2;
    localparam int LED_MOD    = 1 << LED_W;
    localparam int DELAY_MAXV = (1 << DELAY_W) - 1;
    localparam int PERIOD_CYC = (DELAY_INIT + 1) * TICK_DIV;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               faster = 1'b0;
    logic               slower = 1'b0;
    logic               pause = 1'b0;
    logic               write = 1'b0;
    logic [1:0]         address = 2'd0;
    logic [7:0]         writedata = 8'd0;
    logic [LED_W-1:0]   led;
    logic [DELAY_W-1:0] delay;
    logic [1:0]         mode;
    logic               step;

    led_pattern_ctrl #(
        .LED_W(LED_W), .DELAY_W(DELAY_W), .TICK_DIV(TICK_DIV), .DELAY_INIT(DELAY_INIT)
    ) dut (
        .clk(clk), .reset(reset), .faster(faster), .slower(slower), .pause(pause),
        .write(write), .address(address), .writedata(writedata),
        .led(led), .delay(delay), .mode(mode), .step(step)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: the pattern as an integer, timing as a cycle phase
    // within the base tick plus the number of whole ticks elapsed.
    int m_led, m_delay, m_mode, m_pat, m_sp, m_phase, m_ticks, m_going_right, m_step;

    typedef struct {
        logic f;
        logic s;
        logic w;
        logic [1:0] a;
        logic [7:0] d;
        int   exp_delay;
        int   exp_mode;
    } vec_t;

    vec_t tbl[13];
    int   exp_b[16];

    function automatic int rotl(int v);
        return ((v * 2) + (v / (LED_MOD / 2))) % LED_MOD;
    endfunction

    function automatic int rotr(int v);
        return (v / 2) + ((v % 2) * (LED_MOD / 2));
    endfunction

    task automatic model_reset();
        m_led = 1; m_delay = DELAY_INIT; m_mode = 0; m_pat = 1; m_sp = 0;
        m_phase = 0; m_ticks = 0; m_going_right = 0; m_step = 0;
    endtask

    task automatic model_advance();
        bit held, rst_strobe, tick, fire;
        int nled, ngr;
        if (reset) begin
            model_reset();
            return;
        end
        held       = pause || (m_sp != 0);
        rst_strobe = write && (address == 2'd3) && writedata[1];
        tick       = !held && (m_phase == TICK_DIV - 1);
        fire       = tick && (m_ticks >= m_delay);
        nled = m_led;
        ngr  = m_going_right;
        if (fire) begin
            if (m_mode == 0) nled = rotl(m_led);
            else if (m_mode == 1) nled = rotr(m_led);
            else if (m_mode == 3) nled = (m_led + 1) % LED_MOD;
            else begin
                if (!m_going_right && m_led >= LED_MOD / 2) begin ngr = 1; nled = rotr(m_led); end
                else if (m_going_right && (m_led % 2) == 1) begin ngr = 0; nled = rotl(m_led); end
                else nled = m_going_right ? rotr(m_led) : rotl(m_led);
            end
        end
        if (write && address == 2'd1 && writedata[1:0] == 2'd2 && m_mode != 2) ngr = 0;
        m_step = (fire && !rst_strobe) ? 1 : 0;
        if (!held) m_phase = (m_phase + 1) % TICK_DIV;
        if (tick) m_ticks = fire ? 0 : m_ticks + 1;
        if (rst_strobe) begin
            nled = m_pat; ngr = 0; m_phase = 0; m_ticks = 0;
        end
        if (write && address == 2'd0) m_delay = writedata % (DELAY_MAXV + 1);
        else if (faster && !slower && m_delay > 0) m_delay = m_delay - 1;
        else if (slower && !faster && m_delay < DELAY_MAXV) m_delay = m_delay + 1;
        if (write && address == 2'd1) m_mode = writedata % 4;
        if (write && address == 2'd2) m_pat = writedata % LED_MOD;
        if (write && address == 2'd3) m_sp = writedata % 2;
        m_led = nled;
        m_going_right = ngr;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_model();
        n_vec++;
        if (led !== LED_W'(m_led) || delay !== DELAY_W'(m_delay) ||
            mode !== 2'(m_mode) || step !== 1'(m_step)) begin
            n_err++;
            $display("FAIL model t=%0t: led=%h/%h delay=%0d/%0d mode=%0d/%0d step=%0d/%0d (got/expected)",
                     $time, led, m_led, delay, m_delay, mode, m_mode, step, m_step);
        end
    endtask

    // One clock: model follows the inputs present before the edge.
    task automatic cycle();
        model_advance();
        @(posedge clk);
        #1;
        check_model();
        faster = 1'b0;
        slower = 1'b0;
        write  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        write = 1'b1;
        address = a;
        writedata = d;
        cycle();
    endtask

    task automatic wait_step(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            n++;
            if (step) break;
        end
        n_vec++;
        if (!step) begin
            n_err++;
            $display("FAIL step_timeout t=%0t: no step within %0d cycles", $time, limit);
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("async_led", int'(led), 1);
        check("async_delay", int'(delay), DELAY_INIT);
        check("async_mode", int'(mode), 0);
        check("async_step", int'(step), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        faster = 1'b0; slower = 1'b0; write = 1'b0; pause = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int moved;

        //          f     s     w     a     d      delay mode
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1,  0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 0,  0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 0,  0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1,  0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1,  0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h0F, 15, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 15, 0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h05, 5,  0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 2'd0, 8'h37, 7,  0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'h05, 5,  0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'hFE, 5,  2};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd1, 8'h03, 5,  3};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h00, 4,  0};

        exp_b = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                  8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

        #2;
        do_reset();

        // Register / delay vector table.
        for (int i = 0; i < 13; i++) begin
            faster = tbl[i].f; slower = tbl[i].s; write = tbl[i].w;
            address = tbl[i].a; writedata = tbl[i].d;
            cycle();
            check($sformatf("tbl%0d_delay", i), int'(delay), tbl[i].exp_delay);
            check($sformatf("tbl%0d_mode", i), int'(mode), tbl[i].exp_mode);
        end

        // Mode 0 period and rotate-left sequence with wrap.
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            wait_step(100, n);
            check($sformatf("rol_gap%0d", k), n, PERIOD_CYC);
            check($sformatf("rol_led%0d", k), int'(led), 1 << (k % 8));
        end

        // faster x3 saturates at 0 and gives a 4-cycle period; slower saturates.
        for (int k = 0; k < 3; k++) begin
            faster = 1'b1;
            cycle();
        end
        check("faster_sat", int'(delay), 0);
        wait_step(100, n);
        wait_step(100, n);
        check("fast_gap", n, TICK_DIV);
        for (int k = 0; k < 20; k++) begin
            slower = 1'b1;
            cycle();
        end
        check("slower_sat", int'(delay), DELAY_MAXV);
        faster = 1'b1; slower = 1'b1;
        cycle();
        check("both_keys", int'(delay), DELAY_MAXV);

        // Bounce from 0x01.
        do_reset();
        wr(2'd1, 8'h02);
        for (int k = 0; k < 16; k++) begin
            wait_step(100, n);
            check($sformatf("bounce%0d", k), int'(led), exp_b[k]);
        end

        // Pattern write, restart, rotate right and count wrap.
        do_reset();
        wr(2'd2, 8'hA5);
        check("pat_no_effect", int'(led), 1);
        wr(2'd3, 8'h02);
        check("restart_a5", int'(led), 8'hA5);
        wr(2'd1, 8'h01);
        wait_step(100, n);
        check("ror_a5", int'(led), 8'hD2);
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h02);
        check("restart_ff", int'(led), 8'hFF);
        wr(2'd1, 8'h03);
        wait_step(100, n);
        check("count_wrap", int'(led), 0);

        // Soft pause with restart while held.
        wr(2'd3, 8'h01);
        moved = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (step || led != 8'h00) moved++;
        end
        check("soft_pause_frozen", moved, 0);
        wr(2'd3, 8'h03);
        check("restart_held", int'(led), 8'hFF);
        wr(2'd3, 8'h00);

        // pause mid-period, then the remaining count completes.
        do_reset();
        for (int k = 0; k < 5; k++) cycle();
        pause = 1'b1;
        moved = 0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (step || led != 8'h01) moved++;
        end
        check("pause_frozen", moved, 0);
        pause = 1'b0;
        wait_step(100, n);
        check("pause_resume_gap", n, 7);

        // Lowering delay to 0 while tick count is 2 steps on the next tick.
        do_reset();
        wr(2'd0, 8'h05);
        for (int k = 0; k < 7; k++) cycle();
        wr(2'd0, 8'h00);
        check("low_delay_s9", int'(step), 0);
        cycle();
        cycle();
        check("low_delay_s11", int'(step), 0);
        cycle();
        check("low_delay_s12", int'(step), 1);

        // Reset asserted while step is high after non-default settings.
        wr(2'd1, 8'h03);
        wr(2'd0, 8'h01);
        wait_step(100, n);
        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            faster    = ($urandom % 12) == 0;
            slower    = ($urandom % 12) == 0;
            pause     = ($urandom % 6) == 0;
            write     = ($urandom % 8) == 0;
            address   = 2'($urandom);
            writedata = 8'($urandom);
            cycle();
        end
        pause = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
